filter_window_ctrl: RTL and testbench
=====================================

Name: filter_window_ctrl

Overview:
- Frame-level sequencer for the 3x3 neighbourhood filter.
- Accepts a raster pixel stream and builds 3x3 windows using two line buffers.
- Drives the nine window pixels plus the `act` strobe into the filter.
- Tracks the filter's fixed pipeline latency to produce the output write strobe and write address. Signals `done` when the last filtered pixel of the frame has been written.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in pixels (>=3)
- FILT_LAT, 8, cycles from `act` high to the matching filtered pixel being valid at the filter output
- AW, 12, output address width; must hold (IMG_W-2)*(IMG_H-2)-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  input pixel valid
- in_pixel  in  8  input pixel, raster order
- in_ready  out  1  controller accepts a pixel this cycle
- win_pixels  out  72  3x3 window; p1 (top-left) in [71:64] down to p9 (bottom-right) in [7:0]; p5 is the centre
- act  out  1  `win_pixels` holds a complete window this cycle
- out_wr  out  1  filtered pixel for `out_addr` is valid at the filter output this cycle
- out_addr  out  AW  linear output address, (r-1)*(IMG_W-2)+(c-1) for window centre (r,c)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final out_wr

Behaviour:
- Reset: every output is 0; FSM=IDLE; counters, line buffers, window registers and the valid delay line are cleared.
- FSM states:
  - IDLE: waits for `start`; on `start` -> RUN, clears counters.
  - RUN: `in_ready`=1. A pixel is accepted when in_valid&&in_ready. After accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: `in_ready`=0; waits until the output count equals (IMG_W-2)*(IMG_H-2) -> DONE.
  - DONE: `done`=1 for one cycle -> IDLE.
- `busy`=1 in RUN and DRAIN.
- `start` outside IDLE is ignored.
- Counters:
  - col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accept.
  - col wraps to 0 and row increments at col=IMG_W-1.
- Window build, on each accept:
  - Each line buffer shifts by one. Line buffer 0 delays in_pixel by IMG_W; line buffer 1 delays line buffer 0 by IMG_W.
  - The 3x3 register array shifts left. The new right column is {lb1 out, lb0 out, in_pixel} for the top, middle and bottom rows respectively.
- `act`:
  - Registered; high the cycle after an accept with row>=2 and col>=2; low otherwise.
  - No act for col 0/1 (row wrap) or rows 0/1.
  - `win_pixels` is held stable when `act` is low.
- Input gaps: no accept means no shift and no act. The downstream filter advances every cycle, so the delay line also advances every cycle.
- Latency tracking:
  - A FILT_LAT-deep shift register carries `act`; `out_wr` is its tail.
  - `out_addr` starts at 0 at frame start and increments after each out_wr.
  - Windows are issued in raster order, so addresses are 0,1,2,... contiguous.
- Simultaneous events: `done` and a new `start` in the same cycle -> start ignored (not IDLE yet).
- Reset mid-frame: immediate abort; all state cleared; no done.

Decomposition:
- Package filter_pkg:
  - PIX_W=8
  - state enum {IDLE, RUN, DRAIN, DONE}
  - window slot index constants P1..P9
  - default FILT_LAT
- Sub-module line_buffer (parameters DEPTH, WIDTH): shift-enable delay line, instantiated twice.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; in_ready=0.
- Continuous frame (IMG_W=5, IMG_H=4, FILT_LAT=8), pixels 0..19, in_valid always 1:
  - first act the cycle after pixel 12 is accepted, with window {0,1,2,5,6,7,10,11,12};
  - exactly 6 act pulses;
  - out_wr 8 cycles after each act, out_addr 0..5;
  - done one cycle after out_addr 5 is written; busy then drops.
- Row wrap: same frame -> no act after pixels 15 and 16 (col 0/1). The act after pixel 17 has window {5,6,7,10,11,12,15,16,17}.
- Gapped input (in_valid toggling 1,0,0,1...) -> same 6 windows and addresses; act spacing follows the gaps; out_wr stays exactly 8 cycles after each act.
- `start` pulsed during RUN and during DRAIN -> no effect; a second frame started after done reproduces identical outputs.
- Reset after 10 pixels -> outputs cleared, no done. Fresh start then completes a full frame correctly.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 window controller.
// Window slots P1..P9 are raster order within the window; P5 is the centre.
package filter_pkg;

   localparam int PIX_W        = 8;
   localparam int FILT_LAT_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int P3 = 2;
   localparam int P4 = 3;
   localparam int P5 = 4;
   localparam int P6 = 5;
   localparam int P7 = 6;
   localparam int P8 = 7;
   localparam int P9 = 8;

   // P1 sits in the top byte of the packed window, P9 in the bottom byte
   function automatic int slot_lsb(input int slot);
      return (P9 - slot) * PIX_W;
   endfunction

endpackage

// File: rtl/filter_window_ctrl_line_buffer.sv
// Shift-enable delay line: dout is the sample written DEPTH enables ago.
// Single-cycle shift per enable; no backpressure, the caller gates en.
module line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (en) begin
         mem_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/filter_window_ctrl.sv
// Frame sequencer: builds 3x3 windows from a raster stream, issues act one cycle after
// the completing pixel, and emits out_wr FILT_LAT cycles after each act; in_ready only in RUN.
module filter_window_ctrl
   import filter_pkg::*;
#(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64,
   parameter int FILT_LAT = FILT_LAT_DEF,
   parameter int AW       = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   input  logic [PIX_W-1:0]   in_pixel,
   output logic               in_ready,
   output logic [9*PIX_W-1:0] win_pixels,
   output logic               act,
   output logic               out_wr,
   output logic [AW-1:0]      out_addr,
   output logic               busy,
   output logic               done
);

   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);
   localparam int OCW   = $clog2(N_OUT + 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [OCW-1:0]     ocnt_q, ocnt_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [FILT_LAT-1:0] dl_q, dl_d;
   logic               act_q, act_d;
   logic [PIX_W-1:0]   win_q [9];
   logic [PIX_W-1:0]   win_d [9];
   logic [9*PIX_W-1:0] wout_q, wout_d;
   logic [PIX_W-1:0]   lb0_out, lb1_out;
   logic               accept, clr, last_pix;

   assign accept   = (state_q == RUN) && in_valid;
   assign clr      = (state_q == IDLE) && start;
   assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .din  (in_pixel),
      .dout (lb0_out)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .din  (lb0_out),
      .dout (lb1_out)
   );

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (accept) begin
         if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Window shifts left on accept; right column comes from the two line buffers and the live pixel
   always_comb begin
      for (int s = 0; s < 9; s++) win_d[s] = win_q[s];
      act_d = 1'b0;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r + 1];
            win_d[3*r + 1] = win_q[3*r + 2];
         end
         win_d[P3] = lb1_out;
         win_d[P6] = lb0_out;
         win_d[P9] = in_pixel;
         act_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      end
      wout_d = wout_q;
      if (act_d) begin
         for (int s = 0; s < 9; s++) wout_d[slot_lsb(s) +: PIX_W] = win_d[s];
      end
   end

   // The filter pipeline advances every cycle regardless of input gaps
   always_comb begin
      dl_d[0] = act_q;
      for (int i = 1; i < FILT_LAT; i++) dl_d[i] = dl_q[i-1];
   end

   always_comb begin
      addr_d = addr_q;
      ocnt_d = ocnt_q;
      if (clr) begin
         addr_d = '0;
         ocnt_d = '0;
      end else if (out_wr) begin
         addr_d = addr_q + AW'(1);
         ocnt_d = ocnt_q + OCW'(1);
      end
   end

   // Looking at ocnt_d lets done land the cycle right after the final write
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && last_pix) state_d = DRAIN;
         DRAIN:   if (ocnt_d == OCW'(N_OUT)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         ocnt_q  <= '0;
         addr_q  <= '0;
         dl_q    <= '0;
         act_q   <= 1'b0;
         wout_q  <= '0;
         for (int s = 0; s < 9; s++) win_q[s] <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         ocnt_q  <= ocnt_d;
         addr_q  <= addr_d;
         dl_q    <= dl_d;
         act_q   <= act_d;
         wout_q  <= wout_d;
         for (int s = 0; s < 9; s++) win_q[s] <= win_d[s];
      end
   end

   assign in_ready   = (state_q == RUN);
   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign act        = act_q;
   assign out_wr     = dl_q[FILT_LAT-1];
   assign out_addr   = addr_q;
   assign win_pixels = wout_q;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Bench for filter_window_ctrl on a 5x4 frame with an 8-cycle filter latency.
// Windows and write addresses are predicted from the accepted pixels and checked as they appear.
module tb_filter_window_ctrl;

   localparam int W    = 5;
   localparam int H    = 4;
   localparam int L    = 8;
   localparam int AW   = 4;
   localparam int NOUT = (W - 2) * (H - 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_pixel = 8'd0;
   logic          in_ready;
   logic [71:0]   win_pixels;
   logic          act;
   logic          out_wr;
   logic [AW-1:0] out_addr;
   logic          busy;
   logic          done;

   filter_window_ctrl #(.IMG_W(W), .IMG_H(H), .FILT_LAT(L), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_pixel  (in_pixel),
      .in_ready  (in_ready),
      .win_pixels(win_pixels),
      .act       (act),
      .out_wr    (out_wr),
      .out_addr  (out_addr),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [71:0] win;
      int          cyc;
   } act_exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            cyc;
   } wr_exp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   act_exp_t    exp_act_q[$];
   wr_exp_t     exp_wr_q[$];
   logic [71:0] obs_win[$];
   logic [71:0] first_frame[$];
   logic [7:0]  img [H][W];
   int          act_cnt = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          exp_addr = 0;
   int          last_wr_cyc = 0;

   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every act and out_wr must match the next predicted entry
   always @(negedge clk) begin
      if (rst_n) begin
         if (act) begin
            act_cnt++;
            obs_win.push_back(win_pixels);
            checks++;
            if (exp_act_q.size() == 0) begin
               errors++;
               $display("FAIL act_unexpected: act at cycle %0d win=%h, none expected", cyc, win_pixels);
            end else begin
               act_exp_t e;
               e = exp_act_q.pop_front();
               if (win_pixels !== e.win || cyc !== e.cyc) begin
                  errors++;
                  $display("FAIL act_window: got win=%h at cycle %0d, expected win=%h at cycle %0d",
                           win_pixels, cyc, e.win, e.cyc);
               end
            end
         end
         if (out_wr) begin
            wr_cnt++;
            checks++;
            if (exp_wr_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: out_wr at cycle %0d addr=%0d, none expected", cyc, out_addr);
            end else begin
               wr_exp_t e;
               e = exp_wr_q.pop_front();
               if (out_addr !== e.addr || cyc !== e.cyc) begin
                  errors++;
                  $display("FAIL out_wr: got addr=%0d at cycle %0d, expected addr=%0d at cycle %0d",
                           out_addr, cyc, e.addr, e.cyc);
               end
            end
         end
         if (done) done_cnt++;
      end
   end

   // Record one accepted pixel and predict its window/write if it completes a window
   task automatic model_accept(input int n, input logic [7:0] v);
      int r;
      int c;
      logic [71:0] w;
      r = n / W;
      c = n % W;
      img[r][c] = v;
      if (r >= 2 && c >= 2) begin
         w = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
              img[r-1][c-2], img[r-1][c-1], img[r-1][c],
              img[r][c-2],   img[r][c-1],   img[r][c]};
         exp_act_q.push_back('{w, cyc + 1});
         exp_wr_q.push_back('{AW'(exp_addr), cyc + 1 + L});
         last_wr_cyc = cyc + 1 + L;
         exp_addr++;
      end
   endtask

   // mode 0: in_valid always high; mode 1: valid pattern 1,0,0 repeating
   task automatic drive_frame(input int mode, input int mul, input bit poke);
      int n;
      int step;
      int budget;
      int done_before;
      logic [7:0] v;
      act_cnt = 0;
      wr_cnt = 0;
      obs_win.delete();
      exp_addr = 0;
      done_before = done_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL frame_start: busy=%b in_ready=%b, expected 1/1", busy, in_ready);
      end
      n = 0;
      step = 0;
      while (n < W * H && step < 500) begin
         v = 8'(n * mul);
         in_pixel = v;
         in_valid = (mode == 0) ? 1'b1 : (step % 3 == 0);
         start = poke && (step == 4);
         if (in_valid && in_ready) begin
            model_accept(n, v);
            n++;
         end
         step++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b0;
      checks++;
      if (n != W * H) begin
         errors++;
         $display("FAIL frame_feed: accepted %0d pixels, expected %0d", n, W * H);
      end
      if (poke) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      budget = 0;
      while (!done && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, budget);
      end else if (cyc !== last_wr_cyc + 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_timing: done at cycle %0d busy=%b, expected cycle %0d busy=0",
                  cyc, busy, last_wr_cyc + 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL after_done: done=%b busy=%b in_ready=%b, expected 0/0/0", done, busy, in_ready);
      end
      checks++;
      if (act_cnt != NOUT || wr_cnt != NOUT || done_cnt != done_before + 1) begin
         errors++;
         $display("FAIL frame_counts: acts=%0d writes=%0d dones=%0d, expected %0d/%0d/1",
                  act_cnt, wr_cnt, done_cnt - done_before, NOUT, NOUT);
      end
      checks++;
      if (exp_act_q.size() != 0 || exp_wr_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d acts and %0d writes still pending, expected 0/0",
                  exp_act_q.size(), exp_wr_q.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b busy=%b done=%b, expected 0", in_ready, busy, done);
      end
      checks++;
      if (act !== 1'b0 || out_wr !== 1'b0 || out_addr !== '0 || win_pixels !== '0) begin
         errors++;
         $display("FAIL reset_data: act=%b out_wr=%b out_addr=%0d win=%h, expected 0",
                  act, out_wr, out_addr, win_pixels);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle: in_ready=%b busy=%b, expected 0/0", in_ready, busy);
      end
   endtask

   task automatic test_continuous();
      logic [71:0] w0;
      w0 = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
      drive_frame(0, 1, 1'b0);
      first_frame = obs_win;
      checks++;
      if (obs_win.size() < 1 || obs_win[0] !== w0) begin
         errors++;
         $display("FAIL first_window: got %h, expected %h", (obs_win.size() > 0) ? obs_win[0] : 72'h0, w0);
      end
   endtask

   task automatic test_row_wrap();
      logic [71:0] w2;
      logic [71:0] w3;
      w2 = {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14};
      w3 = {8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17};
      checks++;
      if (first_frame.size() < 4 || first_frame[2] !== w2 || first_frame[3] !== w3) begin
         errors++;
         $display("FAIL row_wrap: windows 2/3 = %h / %h, expected %h / %h",
                  (first_frame.size() > 2) ? first_frame[2] : 72'h0,
                  (first_frame.size() > 3) ? first_frame[3] : 72'h0, w2, w3);
      end
   endtask

   task automatic test_gapped();
      drive_frame(1, 7, 1'b0);
   endtask

   task automatic test_start_ignored();
      drive_frame(0, 1, 1'b1);
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (i >= obs_win.size() || obs_win[i] !== first_frame[i]) begin
            errors++;
            $display("FAIL start_ignored_win%0d: got %h, expected %h", i,
                     (i < obs_win.size()) ? obs_win[i] : 72'h0, first_frame[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive_frame(0, 1, 1'b0);
      checks++;
      if (obs_win.size() != NOUT || obs_win[NOUT-1] !== first_frame[NOUT-1]) begin
         errors++;
         $display("FAIL back_to_back: last window %h over %0d acts, expected %h over %0d",
                  (obs_win.size() > 0) ? obs_win[obs_win.size()-1] : 72'h0, obs_win.size(),
                  first_frame[NOUT-1], NOUT);
      end
   endtask

   task automatic test_reset_midframe();
      int dc;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         in_pixel = 8'(n + 40);
         @(negedge clk);
      end
      in_valid = 1'b0;
      dc = done_cnt;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || act !== 1'b0 || out_wr !== 1'b0 ||
          out_addr !== '0 || win_pixels !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe: in_ready=%b busy=%b act=%b out_wr=%b addr=%0d win=%h done=%b, expected all 0",
                  in_ready, busy, act, out_wr, out_addr, win_pixels, done);
      end
      exp_act_q.delete();
      exp_wr_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt != dc || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: dones=%0d busy=%b after abort, expected 0/0", done_cnt - dc, busy);
      end
      drive_frame(0, 3, 1'b0);
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_row_wrap();
      test_gapped();
      test_start_ignored();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
